// File: rtl/mips_mon_pkg.sv
// Shared definitions for the MIPS run monitor: state encodings, signature
// seed and the rotate helper used by the signature fold.
package mips_mon_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_t;

    localparam int unsigned ROT_MAX_W = 64;
    localparam logic [ROT_MAX_W-1:0] SIG_SEED_DEFAULT = '1;

    // Rotates the low w bits of v left by one; bits above w must be zero.
    function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v,
                                                   input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        mask = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/mips_pc_stall_detector.sv
// Tracks the previously sampled PC and flags a self-loop once the PC has
// repeated for STALL_CYCLES consecutive samples.
module mips_pc_stall_detector
    import mips_mon_pkg::*;
#(
    parameter int unsigned W            = 32,
    parameter int unsigned STALL_CYCLES = 3
) (
    input  logic         clock,
    input  logic         reset_global,
    input  logic         clear,
    input  logic         sample_en,
    input  logic [W-1:0] pc_in,
    output logic         stall_hit
);

    localparam int unsigned SCW = $clog2(STALL_CYCLES + 1);

    logic [W-1:0]   last_pc;
    logic           pc_valid;
    logic [SCW-1:0] stall_cnt;
    logic           pc_match;

    assign pc_match  = pc_valid && (pc_in == last_pc);
    assign stall_hit = pc_match && (stall_cnt == SCW'(STALL_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_global) begin
        if (!reset_global) begin
            last_pc   <= '0;
            pc_valid  <= 1'b0;
            stall_cnt <= '0;
        end else if (clear) begin
            last_pc   <= '0;
            pc_valid  <= 1'b0;
            stall_cnt <= '0;
        end else if (sample_en) begin
            last_pc  <= pc_in;
            pc_valid <= 1'b1;
            if (!pc_match)
                stall_cnt <= '0;
            else if (stall_cnt != SCW'(STALL_CYCLES))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller beside the MIPS core: sequences its reset, counts RUN cycles,
// folds ALU results into a signature and ends the run on halt or timeout.
module mips_run_monitor
    import mips_mon_pkg::*;
#(
    parameter int unsigned   W            = 32,
    parameter int unsigned   CW           = 32,
    parameter int unsigned   RESET_CYCLES = 4,
    parameter int unsigned   STALL_CYCLES = 3,
    parameter int unsigned   MAX_CYCLES   = 250,
    parameter bit            HALT_EN      = 1'b0,
    parameter logic [W-1:0]  HALT_PC      = '0,
    parameter logic [W-1:0]  SIG_SEED     = W'(SIG_SEED_DEFAULT)
) (
    input  logic          clock,
    input  logic          reset_global,
    input  logic          restart,
    input  logic [W-1:0]  pc_in,
    input  logic [W-1:0]  alu_in,
    input  logic [W-1:0]  dmem_in,
    output logic          cpu_reset,
    output logic          running,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic [W-1:0]  signature,
    output logic [W-1:0]  last_dmem
);

    localparam int unsigned HCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    mon_state_t     state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           cpu_reset_d, running_d, done_d, timeout_d;
    logic [CW-1:0]  cycle_count_d;
    logic [W-1:0]   signature_d, last_dmem_d;
    logic           sample_en, stall_hit, halt_hit;

    mips_pc_stall_detector #(
        .W            (W),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall (
        .clock        (clock),
        .reset_global (reset_global),
        .clear        (restart),
        .sample_en    (sample_en),
        .pc_in        (pc_in),
        .stall_hit    (stall_hit)
    );

    assign halt_hit = (HALT_EN && (pc_in == HALT_PC)) || stall_hit;

    always_ff @(posedge clock or negedge reset_global) begin
        if (!reset_global) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            signature   <= SIG_SEED;
            last_dmem   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cpu_reset   <= cpu_reset_d;
            running     <= running_d;
            done        <= done_d;
            timeout     <= timeout_d;
            cycle_count <= cycle_count_d;
            signature   <= signature_d;
            last_dmem   <= last_dmem_d;
        end
    end

    // Next values of every registered output; restart overrides halt and timeout.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cpu_reset_d   = cpu_reset;
        running_d     = running;
        done_d        = done;
        timeout_d     = timeout;
        cycle_count_d = cycle_count;
        signature_d   = signature;
        last_dmem_d   = last_dmem;
        sample_en     = 1'b0;

        if (restart) begin
            state_d       = ST_HOLD;
            hold_cnt_d    = '0;
            cpu_reset_d   = 1'b1;
            running_d     = 1'b0;
            done_d        = 1'b0;
            timeout_d     = 1'b0;
            cycle_count_d = '0;
            signature_d   = SIG_SEED;
            last_dmem_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HCW'(RESET_CYCLES - 1)) begin
                        state_d     = ST_RUN;
                        hold_cnt_d  = '0;
                        cpu_reset_d = 1'b0;
                        running_d   = 1'b1;
                    end
                end
                ST_RUN: begin
                    sample_en     = 1'b1;
                    cycle_count_d = cycle_count + 1'b1;
                    signature_d   = W'(rotl1(ROT_MAX_W'(signature), W)) ^ alu_in;
                    if (halt_hit) begin
                        state_d     = ST_DONE;
                        running_d   = 1'b0;
                        done_d      = 1'b1;
                        last_dmem_d = dmem_in;
                    end else if (cycle_count == CW'(MAX_CYCLES - 1)) begin
                        state_d     = ST_TIMEOUT;
                        running_d   = 1'b0;
                        timeout_d   = 1'b1;
                        last_dmem_d = dmem_in;
                    end
                end
                ST_DONE, ST_TIMEOUT: ;
                default: state_d = ST_HOLD;
            endcase
        end
    end

endmodule
